// File: rtl/mmu_walker_pkg.sv
// Shared definitions for the MMU refill walker: FSM states, fault-word/PTE
// bit positions and the table-index width helper.
package mmu_walker_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REQ,
      S_WRITE,
      S_DONE,
      S_ERR
   } walkState_e;

   // PTE fields
   localparam int PTE_V    = 0;
   localparam int PTE_W    = 1;

   // MMU fault word fields
   localparam int FLT_TYPE = 1;
   localparam int FLT_SUP  = 2;
   localparam int FLT_INS  = 3;

   // MMU entry write word fields
   localparam int REG_SET  = 0;
   localparam int REG_V    = 1;
   localparam int REG_W    = 2;

   // Table index is {sup, ins, VPN}: two mode bits above the VPN.
   function automatic int idx_width(input int nmmu);
      return $clog2(nmmu) + 2;
   endfunction

endpackage

// File: rtl/mmu_walker_if.sv
// Handshake/bus bundle between the MMU fault logic, PTE memory and the walker.
// The master modport is the walker side, slave is the MMU/memory side.
interface mmu_walker_if #(
   parameter int RV = 16
) ();

   logic          start;
   logic          abort;
   logic [RV-1:0] fault_reg;
   logic [RV-1:0] table_base;
   logic          mem_req;
   logic [RV-1:0] mem_addr;
   logic          mem_ack;
   logic [RV-1:0] mem_rdata;
   logic          mmu_reg_write;
   logic [RV-1:0] mmu_reg_data;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      input  start,
      input  abort,
      input  fault_reg,
      input  table_base,
      input  mem_ack,
      input  mem_rdata,
      output mem_req,
      output mem_addr,
      output mmu_reg_write,
      output mmu_reg_data,
      output busy,
      output done,
      output err
   );

   modport slave (
      output start,
      output abort,
      output fault_reg,
      output table_base,
      output mem_ack,
      output mem_rdata,
      input  mem_req,
      input  mem_addr,
      input  mmu_reg_write,
      input  mmu_reg_data,
      input  busy,
      input  done,
      input  err
   );

endinterface

// File: rtl/mmu_walker.sv
// Hardware refill engine: on a plain MMU miss it fetches one PTE and installs
// it through the MMU register port; protection faults and invalid PTEs go to software.
module mmu_walker
   import mmu_walker_pkg::*;
#(
   parameter int RV      = 16,
   parameter int PA      = RV,
   parameter int VA      = RV,
   parameter int NMMU    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   mmu_walker_if.master bus
);

   localparam int VPNW      = $clog2(NMMU);
   localparam int IDXW      = idx_width(NMMU);
   localparam int UNTOUCHED = VA - VPNW;
   localparam int PPNW      = PA - UNTOUCHED;
   localparam int CNTW      = $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

   walkState_e    state_q, state_d;
   logic [RV-1:0] fault_q, fault_d;
   logic [RV-1:0] pte_q, pte_d;
   logic [RV-1:0] memAddr_q, memAddr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic          abort_q, abort_d;

   logic [IDXW-1:0] idx;
   logic [RV-1:0]   idxOff;
   logic [RV-1:0]   regData;
   logic            abortSeen;
   logic            unusedBits;

   assign idx       = {fault_q[FLT_SUP], fault_q[FLT_INS], fault_q[VA-1 -: VPNW]};
   assign idxOff    = RV'({idx, 1'b0});
   assign abortSeen = abort_q | bus.abort;
   assign unusedBits = ^{fault_q, pte_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         fault_q   <= '0;
         pte_q     <= '0;
         memAddr_q <= '0;
         cnt_q     <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fault_q   <= fault_d;
         pte_q     <= pte_d;
         memAddr_q <= memAddr_d;
         cnt_q     <= cnt_d;
         abort_q   <= abort_d;
      end
   end

   // An abort during REQ cannot withdraw the request, so it is remembered and
   // the walk drains silently on ack or timeout.
   always_comb begin
      state_d   = state_q;
      fault_d   = fault_q;
      pte_d     = pte_q;
      memAddr_d = memAddr_q;
      cnt_d     = cnt_q;
      abort_d   = abort_q;
      unique case (state_q)
         S_IDLE: begin
            if (!bus.abort && bus.start) begin
               fault_d = bus.fault_reg;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (!fault_q[FLT_TYPE]) begin
               state_d = S_ERR;
            end else begin
               memAddr_d = bus.table_base + idxOff;
               cnt_d     = '0;
               abort_d   = 1'b0;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.abort) begin
               abort_d = 1'b1;
            end
            if (bus.mem_ack) begin
               pte_d = bus.mem_rdata;
               if (abortSeen) begin
                  state_d = S_IDLE;
               end else if (bus.mem_rdata[PTE_V]) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_ERR;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = abortSeen ? S_IDLE : S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WRITE: begin
            state_d = bus.abort ? S_IDLE : S_DONE;
         end
         S_DONE, S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Entry word is only driven while writing so the port reads zero otherwise.
   always_comb begin
      regData = '0;
      if (state_q == S_WRITE) begin
         regData[RV-1 -: PPNW] = pte_q[RV-1 -: PPNW];
         regData[REG_W]        = pte_q[PTE_W];
         regData[REG_V]        = 1'b1;
         regData[REG_SET]      = 1'b1;
      end
   end

   assign bus.mem_req       = (state_q == S_REQ);
   assign bus.mem_addr      = memAddr_q;
   assign bus.mmu_reg_write = (state_q == S_WRITE);
   assign bus.mmu_reg_data  = regData;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = (state_q == S_DONE);
   assign bus.err           = (state_q == S_ERR);

   property pOnePulse;
      @(posedge clk) disable iff (reset)
         $onehot0({bus.mmu_reg_write, bus.done, bus.err});
   endproperty
   assert property (pOnePulse);

   property pAddrStable;
      @(posedge clk) disable iff (reset)
         bus.mem_req |=> (!bus.mem_req || $stable(bus.mem_addr));
   endproperty
   assert property (pAddrStable);

endmodule
